note_register_bank: RTL and testbench
=====================================

NOTE_REGISTER_BANK -- requirements
Module: note_register_bank

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of voice register sets (legal range 1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0010, bus address of voice 0 offset 0x00.
REQ-003 SHALL have parameter VOICE_STRIDE, default 16'h0020, address distance between voices (power of two, at least 0x20).
REQ-004 SHALL have ports, one per line:
- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- BusAddress  in  16  register address
- BusDataIn  in  8  write data
- BusDataOut  out  8  read data
- BusDataOE  out  1  high while BusDataOut is to drive the shared data bus
- BusReadWrite  in  1  1 = write, 0 = read
- BusClock  in  1  asynchronous bus strobe; access on rising edge
- Gate  out  NUM_VOICES  per-voice gate
- GateRise  out  NUM_VOICES  one-cycle pulse on Gate 0->1
- GateFall  out  NUM_VOICES  one-cycle pulse on Gate 1->0
- Incr, PulseWidth, Attack, Decay, Sustain, Release  out  24*NUM_VOICES each  per-voice fields, voice v at bits [24v+23:24v]
- WaveType  out  2*NUM_VOICES  per-voice waveform select
- Linear  out  NUM_VOICES  per-voice linear-envelope flag

Function
REQ-005 SHALL synchronise BusClock through two flops and detect rising/falling edges on the synchronised signal.
REQ-006 SHALL sample BusAddress, BusDataIn, BusReadWrite in the cycle a rising edge is detected; the bus holds them stable across the strobe.
REQ-007 Per-voice offset map (offset = BusAddress - BASE_ADDR - v*VOICE_STRIDE): 0x00 Gate bit0; 0x01-03 Incr; 0x04 WaveType bits[1:0]; 0x05-07 PulseWidth; 0x08-0A Attack; 0x0B-0D Decay; 0x0E-10 Sustain; 0x11-13 Release; 0x14 Linear bit0; 24-bit fields little-endian (lowest address = bits[7:0]).
REQ-008 Offsets 0x15..VOICE_STRIDE-1, addresses below BASE_ADDR, and voices >= NUM_VOICES: writes ignored, reads return 8'h00.
REQ-009 Write: addressed output SHALL reflect new value on the cycle after edge detection (3 Clock cycles after BusClock rise, sync latency included); unused bits of single-byte registers ignored.
REQ-010 Read: BusDataOut SHALL be registered with the addressed byte of the live value on the edge-detect cycle; BusDataOE SHALL go high the same cycle and low the cycle after the synchronised falling edge; BusDataOE SHALL be 0 during writes.
REQ-011 GateRise/GateFall SHALL pulse for exactly one Clock cycle, the cycle Gate changes; rewriting the same Gate value SHALL produce no pulse.
REQ-012 At most one access per BusClock rise; a rise before the previous falling edge is impossible by synchronisation, so no simultaneous-access arbitration is required.

Reset
REQ-013 Reset SHALL asynchronously clear: Gate, GateRise, GateFall, Incr, WaveType, Attack, Decay, Sustain, Release, Linear, BusDataOut, BusDataOE, shadow registers, synchroniser flops to 0; PulseWidth to 24'h7FFFFF.
REQ-014 Reset asserted mid-access SHALL abort it; no partial write survives; first access after release needs a fresh BusClock rise.

Configuration
REQ-015 With macro NOTE_REG_ATOMIC_EN defined: writes to byte 0 and byte 1 of a 24-bit field SHALL go to a per-field shadow; a byte-2 write SHALL commit {byte2, shadow[15:0]} to the live field in one cycle; reads return live value.
REQ-016 Without NOTE_REG_ATOMIC_EN: each byte write SHALL update the live field byte directly; no shadow registers exist.

Verification
REQ-017 Reset release, read 0x0015..0x0017 -> 8'hFF, 8'hFF, 8'h7F; read 0x0011 -> 8'h00; all GateRise/GateFall 0.
REQ-018 Write 0x0011/12/13 = FF,FF,0F -> Incr[23:0]=24'h0FFFFF; with NOTE_REG_ATOMIC_EN unchanged (0) until byte 2 written, without it shows 0000FF after first byte.
REQ-019 Write 0x0030=01 then 0x0030=01 then 0x0030=00 -> Gate[1] 0->1 with one GateRise[1] pulse, no pulse on repeat write, one GateFall[1] pulse on clear.
REQ-020 Write 0x0034=FE, 0x0044=03 -> WaveType[3:2]=2'b10, Linear[1]=1; read 0x0034 -> 8'h02.
REQ-021 With NUM_VOICES=4, write 0x0090=01 and 0x0025=AA -> no output changes; reads of both -> 8'h00.
REQ-022 Assert Reset between byte 1 and byte 2 of Attack write to 0x0018 -> Attack stays 0 after byte 2 alone completes post-reset under NOTE_REG_ATOMIC_EN (shadow cleared, commit yields 24'hXX0000 with only byte 2 set).

Source files
------------

// File: rtl/note_register_bank.sv
// Byte-addressed register bank holding per-voice synth note parameters, written over an async strobed bus.
// Optional macro NOTE_REG_ATOMIC_EN: 24-bit fields commit atomically when their top byte is written.
module note_register_bank #(
    parameter int          NUM_VOICES   = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h0010,
    parameter logic [15:0] VOICE_STRIDE = 16'h0020
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [15:0]             BusAddress,
    input  logic [7:0]              BusDataIn,
    output logic [7:0]              BusDataOut,
    output logic                    BusDataOE,
    input  logic                    BusReadWrite,
    input  logic                    BusClock,
    output logic [NUM_VOICES-1:0]   Gate,
    output logic [NUM_VOICES-1:0]   GateRise,
    output logic [NUM_VOICES-1:0]   GateFall,
    output logic [24*NUM_VOICES-1:0] Incr,
    output logic [24*NUM_VOICES-1:0] PulseWidth,
    output logic [24*NUM_VOICES-1:0] Attack,
    output logic [24*NUM_VOICES-1:0] Decay,
    output logic [24*NUM_VOICES-1:0] Sustain,
    output logic [24*NUM_VOICES-1:0] Release,
    output logic [2*NUM_VOICES-1:0] WaveType,
    output logic [NUM_VOICES-1:0]   Linear
);
    localparam int          SHIFT  = $clog2(VOICE_STRIDE);
    localparam int          NF     = 6;
    localparam logic [23:0] PW_RST = 24'h7FFFFF;
    // first byte offset of Incr, PulseWidth, Attack, Decay, Sustain, Release
    localparam logic [4:0]  FBASE [NF] = '{5'h01, 5'h05, 5'h08, 5'h0B, 5'h0E, 5'h11};

    logic       s1_q, s2_q, s3_q;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;
    logic [NUM_VOICES-1:0] gate_q, gate_d, rise_q, rise_d, fall_q, fall_d, lin_q, lin_d;
    logic [NUM_VOICES-1:0][1:0] wave_q, wave_d;
    logic [NUM_VOICES-1:0][NF-1:0][23:0] fld_q, fld_d;
`ifdef NOTE_REG_ATOMIC_EN
    logic [NUM_VOICES-1:0][NF-1:0][15:0] sh_q, sh_d;
`endif
    logic [7:0] dout_q, dout_d;
    logic       oe_q, oe_d;

    logic [15:0] off_full, voice_full, offset;
    logic [4:0]  off5;
    logic        hit, is_gate, is_wave, is_lin, is_fld;
    logic [2:0]  fsel;
    logic [1:0]  bsel;
    logic [7:0]  rd_byte;
    logic        bus_rise, bus_fall;

    always_comb begin
        off_full   = BusAddress - BASE_ADDR;
        voice_full = off_full >> SHIFT;
        offset     = off_full & (VOICE_STRIDE - 16'd1);
        off5       = offset[4:0];
        hit        = (BusAddress >= BASE_ADDR) && (voice_full < 16'(NUM_VOICES))
                     && (offset <= 16'h0014);
        is_gate = (off5 == 5'h00);
        is_wave = (off5 == 5'h04);
        is_lin  = (off5 == 5'h14);
        is_fld  = 1'b0;
        fsel    = 3'd0;
        bsel    = 2'd0;
        for (int i = 0; i < NF; i++) begin
            if (off5 >= FBASE[i] && off5 < FBASE[i] + 5'd3) begin
                is_fld = 1'b1;
                fsel   = 3'(i);
                bsel   = 2'(off5 - FBASE[i]);
            end
        end
        rd_byte = 8'h00;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (hit && voice_full == 16'(v)) begin
                if (is_gate) rd_byte = {7'b0, gate_q[v]};
                if (is_wave) rd_byte = {6'b0, wave_q[v]};
                if (is_lin)  rd_byte = {7'b0, lin_q[v]};
                if (is_fld)  rd_byte = fld_q[v][fsel][{bsel, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        // strobes are ignored until BusClock has been seen low after reset,
        // so an access cut by reset cannot replay when reset releases
        settle_d = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
        armed_d  = armed_q | ((settle_q == 2'd0) & ~s2_q);
        bus_rise = armed_q & s2_q & ~s3_q;
        bus_fall = ~s2_q & s3_q;
        gate_d = gate_q;
        wave_d = wave_q;
        lin_d  = lin_q;
        fld_d  = fld_q;
`ifdef NOTE_REG_ATOMIC_EN
        sh_d   = sh_q;
`endif
        dout_d = dout_q;
        oe_d   = bus_fall ? 1'b0 : oe_q;
        if (bus_rise) begin
            if (BusReadWrite) begin
                oe_d = 1'b0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (hit && voice_full == 16'(v)) begin
                        if (is_gate) gate_d[v] = BusDataIn[0];
                        if (is_wave) wave_d[v] = BusDataIn[1:0];
                        if (is_lin)  lin_d[v]  = BusDataIn[0];
                        if (is_fld) begin
`ifdef NOTE_REG_ATOMIC_EN
                            if (bsel == 2'd2)
                                fld_d[v][fsel] = {BusDataIn, sh_q[v][fsel]};
                            else
                                sh_d[v][fsel][{bsel[0], 3'b000} +: 8] = BusDataIn;
`else
                            fld_d[v][fsel][{bsel, 3'b000} +: 8] = BusDataIn;
`endif
                        end
                    end
                end
            end else begin
                dout_d = rd_byte;
                oe_d   = 1'b1;
            end
        end
        rise_d = gate_d & ~gate_q;
        fall_d = ~gate_d & gate_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            settle_q <= 2'd2;
            armed_q  <= 1'b0;
            gate_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            wave_q   <= '0;
            lin_q    <= '0;
            fld_q    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) fld_q[v][1] <= PW_RST;
`ifdef NOTE_REG_ATOMIC_EN
            sh_q     <= '0;
`endif
            dout_q   <= 8'h00;
            oe_q     <= 1'b0;
        end else begin
            s1_q     <= BusClock;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            settle_q <= settle_d;
            armed_q  <= armed_d;
            gate_q   <= gate_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            wave_q   <= wave_d;
            lin_q    <= lin_d;
            fld_q    <= fld_d;
`ifdef NOTE_REG_ATOMIC_EN
            sh_q     <= sh_d;
`endif
            dout_q   <= dout_d;
            oe_q     <= oe_d;
        end
    end

    assign Gate       = gate_q;
    assign GateRise   = rise_q;
    assign GateFall   = fall_q;
    assign Linear     = lin_q;
    assign BusDataOut = dout_q;
    assign BusDataOE  = oe_q;

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_out
        assign Incr[24*gv +: 24]       = fld_q[gv][0];
        assign PulseWidth[24*gv +: 24] = fld_q[gv][1];
        assign Attack[24*gv +: 24]     = fld_q[gv][2];
        assign Decay[24*gv +: 24]      = fld_q[gv][3];
        assign Sustain[24*gv +: 24]    = fld_q[gv][4];
        assign Release[24*gv +: 24]    = fld_q[gv][5];
        assign WaveType[2*gv +: 2]     = wave_q[gv];
    end
endmodule

// File: tb/tb_note_register_bank.sv
// Bench for note_register_bank: read data checked by a scoreboard monitor, register outputs checked directly.
module tb_note_register_bank;
`ifdef NOTE_REG_ATOMIC_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif
    localparam int NV = 4;

    logic Clock = 1'b0, Reset = 1'b1, BusReadWrite = 1'b0, BusClock = 1'b0;
    logic [15:0] BusAddress = 16'h0;
    logic [7:0]  BusDataIn = 8'h0, BusDataOut;
    logic        BusDataOE;
    logic [NV-1:0] Gate, GateRise, GateFall, Linear;
    logic [24*NV-1:0] Incr, PulseWidth, Attack, Decay, Sustain, Release;
    logic [2*NV-1:0] WaveType;

    note_register_bank #(.NUM_VOICES(NV), .BASE_ADDR(16'h0010), .VOICE_STRIDE(16'h0020)) dut (
        .Clock(Clock), .Reset(Reset), .BusAddress(BusAddress), .BusDataIn(BusDataIn),
        .BusDataOut(BusDataOut), .BusDataOE(BusDataOE), .BusReadWrite(BusReadWrite),
        .BusClock(BusClock), .Gate(Gate), .GateRise(GateRise), .GateFall(GateFall),
        .Incr(Incr), .PulseWidth(PulseWidth), .Attack(Attack), .Decay(Decay),
        .Sustain(Sustain), .Release(Release), .WaveType(WaveType), .Linear(Linear));

    always #5 Clock = ~Clock;

    int tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    string      nm_q[$];
    logic       oe_prev = 1'b0;
    int         rise1_cnt = 0, fall1_cnt = 0, pulse_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: each rising BusDataOE presents one read result
    always @(negedge Clock) begin
        if (!Reset) begin
            if (BusDataOE && !oe_prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL read_unexpected: got %h expected no read", BusDataOut);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    automatic string n = nm_q.pop_front();
                    check(n, {24'h0, BusDataOut}, {24'h0, e});
                end
            end
            rise1_cnt   += int'(GateRise[1]);
            fall1_cnt   += int'(GateFall[1]);
            pulse_total += $countones(GateRise) + $countones(GateFall);
        end
        oe_prev = BusDataOE;
    end

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge Clock);
        BusAddress = a;
        BusDataIn = d;
        BusReadWrite = rw;
        #3 BusClock = 1'b1;
        repeat (6) @(negedge Clock);
        if (rw) check("oe_low_on_write", {31'h0, BusDataOE}, 32'h0);
        BusClock = 1'b0;
        repeat (6) @(negedge Clock);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        strobe(a, d, 1'b1);
    endtask

    task automatic bus_read(input string nm, input logic [15:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        strobe(a, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge Clock);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);

        check("rst_gate", {28'h0, Gate}, 32'h0);
        check("rst_rise_fall", {24'h0, GateRise, GateFall}, 32'h0);
        check("rst_oe", {31'h0, BusDataOE}, 32'h0);
        check("rst_incr0", {8'h0, Incr[23:0]}, 32'h0);
        check("rst_pw0", {8'h0, PulseWidth[23:0]}, 32'h007FFFFF);
        check("rst_pw3", {8'h0, PulseWidth[95:72]}, 32'h007FFFFF);
        bus_read("rd_0015", 16'h0015, 8'hFF);
        bus_read("rd_0016", 16'h0016, 8'hFF);
        bus_read("rd_0017", 16'h0017, 8'h7F);
        bus_read("rd_0011", 16'h0011, 8'h00);

        bus_write(16'h0011, 8'hFF);
        check("incr_b0", {8'h0, Incr[23:0]}, ATOMIC ? 32'h0 : 32'h000000FF);
        bus_write(16'h0012, 8'hFF);
        check("incr_b1", {8'h0, Incr[23:0]}, ATOMIC ? 32'h0 : 32'h0000FFFF);
        bus_write(16'h0013, 8'h0F);
        check("incr_b2", {8'h0, Incr[23:0]}, 32'h000FFFFF);
        bus_read("rd_0013", 16'h0013, 8'h0F);
        bus_read("rd_0011_after", 16'h0011, 8'hFF);

        rise1_cnt = 0; fall1_cnt = 0; pulse_total = 0;
        bus_write(16'h0030, 8'h01);
        check("gate_set", {28'h0, Gate}, 32'h2);
        check("gate_rise_cnt", rise1_cnt, 1);
        bus_write(16'h0030, 8'h01);
        check("gate_repeat_rise", rise1_cnt, 1);
        check("gate_repeat_fall", fall1_cnt, 0);
        bus_read("rd_0030", 16'h0030, 8'h01);
        bus_write(16'h0030, 8'h00);
        check("gate_clr", {28'h0, Gate}, 32'h0);
        check("gate_fall_cnt", fall1_cnt, 1);
        check("pulse_total", pulse_total, 2);

        bus_write(16'h0034, 8'hFE);
        bus_write(16'h0044, 8'h03);
        check("wavetype", {24'h0, WaveType}, 32'h08);
        check("linear", {28'h0, Linear}, 32'h2);
        bus_read("rd_0034", 16'h0034, 8'h02);
        bus_read("rd_0044", 16'h0044, 8'h01);

        bus_write(16'h0083, 8'hAB);
        check("release_v3", {8'h0, Release[95:72]}, 32'h00AB0000);
        bus_read("rd_0083", 16'h0083, 8'hAB);

        bus_write(16'h0090, 8'h01);
        bus_write(16'h0025, 8'hAA);
        bus_write(16'h0005, 8'h01);
        check("oob_gate", {28'h0, Gate}, 32'h0);
        check("oob_wave", {24'h0, WaveType}, 32'h08);
        check("oob_linear", {28'h0, Linear}, 32'h2);
        check("oob_pw0", {8'h0, PulseWidth[23:0]}, 32'h007FFFFF);
        check("oob_incr0", {8'h0, Incr[23:0]}, 32'h000FFFFF);
        bus_read("rd_0090", 16'h0090, 8'h00);
        bus_read("rd_0025", 16'h0025, 8'h00);
        bus_read("rd_0005", 16'h0005, 8'h00);

        bus_write(16'h0018, 8'h11);
        check("attack_b0", {8'h0, Attack[23:0]}, ATOMIC ? 32'h0 : 32'h00000011);
        // reset lands in the middle of a strobe to byte 1
        @(negedge Clock);
        BusAddress = 16'h0019; BusDataIn = 8'h22; BusReadWrite = 1'b1;
        #3 BusClock = 1'b1;
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst_attack", {8'h0, Attack[23:0]}, 32'h0);
        check("rst_incr", {8'h0, Incr[23:0]}, 32'h0);
        check("rst_pw", {8'h0, PulseWidth[23:0]}, 32'h007FFFFF);
        Reset = 1'b0;
        repeat (6) @(negedge Clock);
        BusClock = 1'b0;
        repeat (6) @(negedge Clock);
        check("abort_attack", {8'h0, Attack[23:0]}, 32'h0);
        bus_write(16'h001A, 8'h55);
        check("attack_post_rst", {8'h0, Attack[23:0]}, 32'h00550000);
        bus_read("rd_001A", 16'h001A, 8'h55);
        bus_read("rd_0018", 16'h0018, 8'h00);

        repeat (10) @(negedge Clock);
        check("reads_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
